// File: rtl/decoder.sv
// Registered RV32I/F instruction field decoder.
//
// Splits a 32-bit instruction into opcode, function codes, integer and FP
// register indices and format-assembled immediate bit patterns, and flags
// opcodes outside the supported set. All outputs are registered and appear
// one clock after the instruction is presented with valid_in.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, clears every output
//   instruction  raw instruction word
//   valid_in     instruction qualifier
//   valid_out    outputs correspond to a decoded instruction
//   illegal      opcode not in the supported set
//   op           instruction[6:0]
//   funct2       R4 fmt field [26:25]
//   funct3       [14:12]
//   funct7       [31:25]
//   rs1, rs2     integer sources [19:15], [24:20]
//   fs1/fs2/fs3  FP sources [19:15], [24:20], [31:27]
//   rd, fd       integer / FP destination [11:7]
//   imm12        I/S/B immediate bit pattern (no sign extension)
//   immhi        U/J immediate bit pattern
//
// Handshake: valid_in is a one-cycle qualifier with no back-pressure; every
// clock edge with valid_in=1 produces exactly one valid_out pulse on the
// following cycle. With valid_in=0 the fields hold and valid_out drops.
module decoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  input  logic            valid_in,
  output logic            valid_out,
  output logic            illegal,
  output logic [6:0]      op,
  output logic [1:0]      funct2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      fs1,
  output logic [4:0]      fs2,
  output logic [4:0]      fs3,
  output logic [4:0]      rd,
  output logic [4:0]      fd,
  output logic [11:0]     imm12,
  output logic [19:0]     immhi
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;

  logic        illegal_n;
  logic [6:0]  op_n;
  logic [1:0]  funct2_n;
  logic [2:0]  funct3_n;
  logic [6:0]  funct7_n;
  logic [4:0]  rs1_n;
  logic [4:0]  rs2_n;
  logic [4:0]  fs1_n;
  logic [4:0]  fs2_n;
  logic [4:0]  fs3_n;
  logic [4:0]  rd_n;
  logic [4:0]  fd_n;
  logic [11:0] imm12_n;
  logic [19:0] immhi_n;

  // Combinational decode: every field defaults to 0 so that anything a
  // format does not use is driven 0 rather than a stray slice.
  always_comb begin
    illegal_n = 1'b0;
    op_n      = instruction[6:0];
    funct2_n  = '0;
    funct3_n  = '0;
    funct7_n  = '0;
    rs1_n     = '0;
    rs2_n     = '0;
    fs1_n     = '0;
    fs2_n     = '0;
    fs3_n     = '0;
    rd_n      = '0;
    fd_n      = '0;
    imm12_n   = '0;
    immhi_n   = '0;
    unique case (instruction[6:0])
      OP_R: begin
        rd_n     = instruction[11:7];
        funct3_n = instruction[14:12];
        rs1_n    = instruction[19:15];
        rs2_n    = instruction[24:20];
        funct7_n = instruction[31:25];
      end
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        rd_n     = instruction[11:7];
        funct3_n = instruction[14:12];
        rs1_n    = instruction[19:15];
        imm12_n  = instruction[31:20];
      end
      OP_STORE: begin
        funct3_n = instruction[14:12];
        rs1_n    = instruction[19:15];
        rs2_n    = instruction[24:20];
        imm12_n  = {instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        funct3_n = instruction[14:12];
        rs1_n    = instruction[19:15];
        rs2_n    = instruction[24:20];
        // Branch offset bits [12:1]; bit 0 is implicitly zero.
        imm12_n  = {instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8]};
      end
      OP_LUI, OP_AUIPC: begin
        rd_n    = instruction[11:7];
        immhi_n = instruction[31:12];
      end
      OP_JAL: begin
        rd_n    = instruction[11:7];
        // Jump offset bits [20:1]; bit 0 is implicitly zero.
        immhi_n = {instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21]};
      end
      OP_FLW: begin
        fd_n     = instruction[11:7];
        funct3_n = instruction[14:12];
        rs1_n    = instruction[19:15];
        imm12_n  = instruction[31:20];
      end
      OP_FSW: begin
        funct3_n = instruction[14:12];
        rs1_n    = instruction[19:15];
        fs2_n    = instruction[24:20];
        imm12_n  = {instruction[31:25], instruction[11:7]};
      end
      OP_FP: begin
        fd_n     = instruction[11:7];
        funct3_n = instruction[14:12];
        fs1_n    = instruction[19:15];
        fs2_n    = instruction[24:20];
        funct7_n = instruction[31:25];
      end
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        fd_n     = instruction[11:7];
        funct3_n = instruction[14:12];
        fs1_n    = instruction[19:15];
        fs2_n    = instruction[24:20];
        funct2_n = instruction[26:25];
        fs3_n    = instruction[31:27];
      end
      default: begin
        illegal_n = 1'b1;
      end
    endcase
  end

  // Output register. Fields only load on valid_in, so an idle cycle keeps
  // the last decode visible while valid_out drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      illegal   <= 1'b0;
      op        <= '0;
      funct2    <= '0;
      funct3    <= '0;
      funct7    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      fs1       <= '0;
      fs2       <= '0;
      fs3       <= '0;
      rd        <= '0;
      fd        <= '0;
      imm12     <= '0;
      immhi     <= '0;
    end else if (valid_in) begin
      valid_out <= 1'b1;
      illegal   <= illegal_n;
      op        <= op_n;
      funct2    <= funct2_n;
      funct3    <= funct3_n;
      funct7    <= funct7_n;
      rs1       <= rs1_n;
      rs2       <= rs2_n;
      fs1       <= fs1_n;
      fs2       <= fs2_n;
      fs3       <= fs3_n;
      rd        <= rd_n;
      fd        <= fd_n;
      imm12     <= imm12_n;
      immhi     <= immhi_n;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed instruction vectors with
// hand-computed expected fields pushed into a queue by the driver, and a
// monitor that pops and compares whenever valid_out is seen.
module tb_decoder;

  typedef struct packed {
    logic        illegal;
    logic [6:0]  op;
    logic [1:0]  funct2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  fs1;
    logic [4:0]  fs2;
    logic [4:0]  fs3;
    logic [4:0]  rd;
    logic [4:0]  fd;
    logic [11:0] imm12;
    logic [19:0] immhi;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0;
  logic        valid_in = 1'b0;
  logic        valid_out;
  logic        illegal;
  logic [6:0]  op;
  logic [1:0]  funct2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, fs1, fs2, fs3, rd, fd;
  logic [11:0] imm12;
  logic [19:0] immhi;

  always #5 clk = ~clk;

  decoder dut (
    .clk(clk), .rst(rst), .instruction(instruction), .valid_in(valid_in),
    .valid_out(valid_out), .illegal(illegal), .op(op), .funct2(funct2),
    .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .fs1(fs1),
    .fs2(fs2), .fs3(fs3), .rd(rd), .fd(fd), .imm12(imm12), .immhi(immhi)
  );

  // ---------------- scoreboard state ----------------
  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".illegal"}, 32'(illegal), 32'(e.illegal));
    check({tag, ".op"},      32'(op),      32'(e.op));
    check({tag, ".funct2"},  32'(funct2),  32'(e.funct2));
    check({tag, ".funct3"},  32'(funct3),  32'(e.funct3));
    check({tag, ".funct7"},  32'(funct7),  32'(e.funct7));
    check({tag, ".rs1"},     32'(rs1),     32'(e.rs1));
    check({tag, ".rs2"},     32'(rs2),     32'(e.rs2));
    check({tag, ".fs1"},     32'(fs1),     32'(e.fs1));
    check({tag, ".fs2"},     32'(fs2),     32'(e.fs2));
    check({tag, ".fs3"},     32'(fs3),     32'(e.fs3));
    check({tag, ".rd"},      32'(rd),      32'(e.rd));
    check({tag, ".fd"},      32'(fd),      32'(e.fd));
    check({tag, ".imm12"},   32'(imm12),   32'(e.imm12));
    check({tag, ".immhi"},   32'(immhi),   32'(e.immhi));
  endtask

  function automatic exp_t blank(input logic [6:0] opc);
    exp_t e;
    e = '0;
    e.op = opc;
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic send(input string name, input logic [31:0] instr, input exp_t e);
    @(negedge clk);
    instruction = instr;
    valid_in = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    instruction = $urandom_range(0, 32'hFFFF_FFFF);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid_out", 32'(valid_out), 32'd0);
        end else begin
          exp_t  e;
          string n;
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check_all(n, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  exp_t e;
  exp_t last;

  initial begin
    // Reset state, asserted from time 0.
    #2;
    check("reset.valid_out", 32'(valid_out), 32'd0);
    check_all("reset", blank(7'h00));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // One edge with valid_in=0 after reset: outputs must stay 0.
    @(negedge clk);
    check("post_reset.valid_out", 32'(valid_out), 32'd0);
    check_all("post_reset", blank(7'h00));

    // Back-to-back directed vectors.
    e = blank(7'd51); e.rd = 1; e.funct3 = 3'b100; e.rs1 = 3; e.rs2 = 2;
    send("xor", 32'h0021C0B3, e);
    e = blank(7'd111); e.rd = 1; e.immhi = 20'h41800;
    send("jal", 32'h000830EF, e);
    e = blank(7'd35); e.funct3 = 3'b001; e.rs1 = 3; e.rs2 = 2; e.imm12 = 12'h021;
    send("sh", 32'h022190A3, e);
    e = blank(7'd99); e.funct3 = 3'b100; e.rs1 = 3; e.rs2 = 2; e.imm12 = 12'h480;
    send("blt", 32'h1021C0E3, e);
    e = blank(7'd103); e.rd = 1; e.rs1 = 3; e.imm12 = 12'h008;
    send("jalr", 32'h008180E7, e);
    e = blank(7'd55); e.rd = 1; e.immhi = 20'h0081A;
    send("lui", 32'h0081A0B7, e);
    e = blank(7'd23); e.rd = 1; e.immhi = 20'h0081A;
    send("auipc", 32'h0081A097, e);
    e = blank(7'h03); e.rd = 5; e.funct3 = 3'b010; e.rs1 = 2; e.imm12 = 12'hFFF;
    send("lw_neg", 32'hFFF12283, e);
    e = blank(7'h07); e.fd = 1; e.funct3 = 3'b010; e.rs1 = 3; e.imm12 = 12'h004;
    send("flw", 32'h0041A087, e);
    e = blank(7'h27); e.funct3 = 3'b010; e.rs1 = 3; e.fs2 = 2; e.imm12 = 12'h008;
    send("fsw", 32'h0021A427, e);
    e = blank(7'h53); e.fd = 1; e.funct3 = 3'b111; e.fs1 = 3; e.fs2 = 2; e.funct7 = 7'd4;
    send("fsub", 32'h0821F0D3, e);
    e = blank(7'h43); e.fd = 1; e.funct3 = 3'b111; e.fs1 = 3; e.fs2 = 2; e.fs3 = 3;
    send("fmadd", 32'h1821F0C3, e);
    e = blank(7'h7F); e.illegal = 1'b1;
    send("illegal", 32'hFFFFFFFF, e);
    last = e;

    // Idle: valid_out drops, fields hold the illegal decode.
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle.valid_out", 32'(valid_out), 32'd0);
      check_all("idle_hold", last);
    end

    // Reset between clock edges right after a decode.
    e = blank(7'd51); e.rd = 1; e.funct3 = 3'b100; e.rs1 = 3; e.rs2 = 2;
    send("xor2", 32'h0021C0B3, e);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset.valid_out", 32'(valid_out), 32'd0);
    check_all("async_reset", blank(7'h00));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset.valid_out", 32'(valid_out), 32'd0);
    check_all("after_reset", blank(7'h00));

    // Drain: every pushed expectation must have been consumed.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Registered RV32I/F instruction field decoder in the PE front end.
- Splits a 32-bit instruction into opcode, function codes, integer/FP register indices, and format-assembled immediates (12-bit low, 20-bit high), plus an illegal-opcode flag.
- Feeds the PE execute stage one cycle after the instruction is presented.

Parameters:
- XLEN, 32, instruction width; fixed, all slicing assumes 32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- instruction  input  32  raw instruction word
- valid_in  input  1  instruction qualifier
- valid_out  output  1  outputs correspond to a decoded instruction
- illegal  output  1  opcode not in supported set
- op  output  7  opcode, instruction[6:0]
- funct2  output  2  R4 fmt field, instruction[26:25]
- funct3  output  3  instruction[14:12]
- funct7  output  7  instruction[31:25]
- rs1, rs2  output  5 each  integer sources, [19:15], [24:20]
- fs1, fs2, fs3  output  5 each  FP sources, [19:15], [24:20], [31:27]
- rd  output  5  integer destination, [11:7]
- fd  output  5  FP destination, [11:7]
- imm12  output  12  I/S/B immediate, unsigned bit pattern, no sign extension
- immhi  output  20  U/J immediate bit pattern

Behaviour:
- Reset (async, rst=1): every output register, including valid_out and illegal, is 0 immediately. Outputs stay 0 until the first valid_in edge after rst falls.
- Latency: 1 cycle. On a rising clk with valid_in=1, all outputs load the decode of instruction and valid_out=1.
- Idle: on a rising clk with valid_in=0, valid_out=0 and all other outputs hold their previous values.
- op is always instruction[6:0]. Any field not used by the format is driven 0.
- R (0110011):
  - rd, funct3, rs1, rs2, funct7 from their slices.
  - imm12=0, immhi=0.
- I (0000011 load, 0010011 op-imm, 1100111 JALR, 1110011 system):
  - rd, funct3, rs1 from their slices.
  - imm12 = instruction[31:20].
- S (0100011):
  - funct3, rs1, rs2 from their slices.
  - imm12 = {instruction[31:25], instruction[11:7]}.
  - rd=0.
- B (1100011):
  - funct3, rs1, rs2 from their slices.
  - imm12 = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]}, i.e. offset bits [12:1].
  - rd=0.
- U (0110111 LUI, 0010111 AUIPC):
  - rd from its slice.
  - immhi = instruction[31:12].
- J (1101111):
  - rd from its slice.
  - immhi = {instruction[31], instruction[19:12], instruction[20], instruction[30:21]}, i.e. offset bits [20:1].
- FLW (0000111): fd, funct3, rs1; imm12 = instruction[31:20].
- FSW (0100111): funct3, rs1, fs2; imm12 as S-type.
- OP-FP (1010011): fd, funct3, fs1, fs2, funct7.
- R4 (1000011, 1000111, 1001011, 1001111): fd, funct3, fs1, fs2, funct2, fs3.
- Any other opcode: illegal=1 and all fields except op are 0. valid_out still asserts.
- Integer and FP register fields are mutually exclusive per opcode; unused ones are 0.
- Back-to-back valid_in: each cycle decodes independently, with no inter-instruction state.
- rst asserted mid-stream: the in-flight decode is discarded.

Test Plan:
- XOR 0x0021C0B3 with valid_in → next cycle: op=51, rd=1, funct3=100b, rs1=3, rs2=2, funct7=0, imm12=0, immhi=0, illegal=0.
- JAL 0x000830EF → op=111, rd=1, immhi=0x41800, rs1=rs2=0, funct3=0. Then SH 0x022190A3 → op=35, rs1=3, rs2=2, funct3=001b, imm12=0x021, rd=0.
- BLT-form 0x1021C0E3 → op=99, imm12=0x480, rs1=3, rs2=2, funct3=100b. Then JALR 0x008180E7 → op=103, imm12=0x008, rs1=3, rd=1.
- LUI 0x0081A0B7 → op=55, rd=1, immhi=0x0081A, imm12=0. Then AUIPC 0x0081A097 → op=23, identical fields.
- FMADD.S 0x1821F0C3 → fd=1, fs1=3, fs2=2, fs3=3, funct2=00b, rd=rs1=rs2=0. Then opcode 0x7F → illegal=1, all fields 0.
- Reset and idle:
  - rst pulsed mid-cycle after a decode → outputs 0 immediately, before any clock edge.
  - valid_in=0 for 2 cycles → valid_out=0 and other outputs hold.
